mem_port_arbiter: RTL and testbench

Shares the single NPC memory port between NR_REQ requesters, typically the IFU (index 0) and the LSU (index 1). It accepts one request at a time through a valid/ready handshake and latches its payload. It drives the request to the memory port, waits for the response, and returns the read data to the granted requester only. Only one transaction is outstanding at any time; the grant stays locked until that requester receives its response.

---
 rtl/npc_bus_pkg.sv | 27 ++
 rtl/mem_port_arbiter_arb_pick.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : npc_bus_pkg
//  Description : Shared NPC bus definitions: memory-port arbiter FSM state
//                encoding, default address/data widths and an index-width
//                helper used to size requester indices.
//  Revision    : 1.0 - initial release
// ============================================================================
package npc_bus_pkg;

    localparam int unsigned NPC_ADDR_W = 32;
    localparam int unsigned NPC_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Width of an index able to address n entries (at least one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pick
//  Description : Combinational requester selection. Searches upward from
//                i_ptr (wrapping past NR_REQ-1 to 0) and returns the first
//                valid requester as a one-hot grant plus its index.
//                With i_ptr tied to 0 this is plain fixed priority.
//  Ports       : i_valid [NR_REQ]  request valid bits
//                i_ptr   [IDX_W]   search start index (< NR_REQ)
//                o_grant [NR_REQ]  one-hot grant, zero when nothing valid
//                o_idx   [IDX_W]   index of the granted requester
//                o_any             at least one requester valid
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_pick
    import npc_bus_pkg::*;
#(
    parameter int unsigned NR_REQ = 2,
    parameter int unsigned IDX_W  = idx_width(NR_REQ)
) (
    input  logic [NR_REQ-1:0] i_valid,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [NR_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    int unsigned w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = 0;
        for (int unsigned k = 0; k < NR_REQ; k++) begin
            // Candidate index = (ptr + k) mod NR_REQ, ptr is always < NR_REQ.
            w_cand = 32'(i_ptr) + k;
            if (w_cand >= NR_REQ) begin
                w_cand = w_cand - NR_REQ;
            end
            if (!o_any && i_valid[w_cand[IDX_W-1:0]]) begin
                o_any                      = 1'b1;
                o_idx                      = w_cand[IDX_W-1:0];
                o_grant[w_cand[IDX_W-1:0]] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares the single NPC memory port between NR_REQ requesters.
//                One transaction outstanding at a time: accept (IDLE),
//                issue to memory (ISSUE), wait for the response (WAIT),
//                return a one-cycle strobe to the granted requester (RESP).
//  Config      : MEM_ARB_RR_EN defined   -> round-robin arbitration
//                MEM_ARB_RR_EN undefined -> fixed priority, index 0 highest
//  Ports       : clock, reset_n (async, active-low)
//                i_req_valid/o_req_ready      per-requester handshake
//                i_req_addr/wen/wdata/wmask   flattened requester payloads
//                o_resp_valid/o_resp_rdata    one-hot response strobe + data
//                o_mem_req_valid/i_mem_req_ready, o_mem_addr/wen/wdata/wmask
//                i_mem_resp_valid/i_mem_rdata memory side
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import npc_bus_pkg::*;
#(
    parameter int unsigned NR_REQ = 2,
    parameter int unsigned ADDR_W = NPC_ADDR_W,
    parameter int unsigned DATA_W = NPC_DATA_W
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NR_REQ-1:0]          i_req_valid,
    output logic [NR_REQ-1:0]          o_req_ready,
    input  logic [NR_REQ*ADDR_W-1:0]   i_req_addr,
    input  logic [NR_REQ-1:0]          i_req_wen,
    input  logic [NR_REQ*DATA_W-1:0]   i_req_wdata,
    input  logic [NR_REQ*DATA_W/8-1:0] i_req_wmask,
    output logic [NR_REQ-1:0]          o_resp_valid,
    output logic [DATA_W-1:0]          o_resp_rdata,
    output logic                       o_mem_req_valid,
    input  logic                       i_mem_req_ready,
    output logic [ADDR_W-1:0]          o_mem_addr,
    output logic                       o_mem_wen,
    output logic [DATA_W-1:0]          o_mem_wdata,
    output logic [DATA_W/8-1:0]        o_mem_wmask,
    input  logic                       i_mem_resp_valid,
    input  logic [DATA_W-1:0]          i_mem_rdata
);

    localparam int unsigned IDX_W  = idx_width(NR_REQ);
    localparam int unsigned MASK_W = DATA_W / 8;
    localparam logic [NR_REQ-1:0] c_one = NR_REQ'(1);

    arb_state_t        r_state;
    logic [IDX_W-1:0]  r_win;
    logic [IDX_W-1:0]  w_ptr;
    logic [NR_REQ-1:0] w_grant;
    logic [IDX_W-1:0]  w_idx;
    logic              w_any;

`ifdef MEM_ARB_RR_EN
    logic [IDX_W-1:0]  r_ptr;
    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    arb_pick #(
        .NR_REQ (NR_REQ),
        .IDX_W  (IDX_W)
    ) u_arb_pick (
        .i_valid (i_req_valid),
        .i_ptr   (w_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Accept is combinational in IDLE; gating with reset_n keeps req_ready
    // low while reset is asserted, like every registered output.
    assign o_req_ready = (reset_n && (r_state == ST_IDLE)) ? w_grant : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_win           <= '0;
            o_resp_valid    <= '0;
            o_resp_rdata    <= '0;
            o_mem_req_valid <= 1'b0;
            o_mem_addr      <= '0;
            o_mem_wen       <= 1'b0;
            o_mem_wdata     <= '0;
            o_mem_wmask     <= '0;
`ifdef MEM_ARB_RR_EN
            r_ptr           <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_win           <= w_idx;
                        o_mem_addr      <= i_req_addr[32'(w_idx)*ADDR_W +: ADDR_W];
                        o_mem_wen       <= i_req_wen[w_idx];
                        o_mem_wdata     <= i_req_wdata[32'(w_idx)*DATA_W +: DATA_W];
                        o_mem_wmask     <= i_req_wmask[32'(w_idx)*MASK_W +: MASK_W];
                        o_mem_req_valid <= 1'b1;
                        r_state         <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (i_mem_req_ready) begin
                        o_mem_req_valid <= 1'b0;
                        r_state         <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Response strobe and data are registered on entry to RESP.
                    if (i_mem_resp_valid) begin
                        o_resp_rdata <= i_mem_rdata;
                        o_resp_valid <= c_one << r_win;
                        r_state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    o_resp_valid <= '0;
`ifdef MEM_ARB_RR_EN
                    if (32'(r_win) == NR_REQ - 1) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= r_win + 1'b1;
                    end
`endif
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter. Directed cases
//                plus randomized transactions checked against a transaction
//                level reference (winner selection, pointer, timing).
//                Honors MEM_ARB_RR_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR-1:0]     req_wen = '0;
    logic [NR*DW-1:0]  req_wdata = '0;
    logic [NR*MW-1:0]  req_wmask = '0;
    logic [NR-1:0]     resp_valid;
    logic [DW-1:0]     resp_rdata;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b0;
    logic [AW-1:0]     mem_addr;
    logic              mem_wen;
    logic [DW-1:0]     mem_wdata;
    logic [MW-1:0]     mem_wmask;
    logic              mem_resp_valid = 1'b0;
    logic [DW-1:0]     mem_rdata = '0;

    int n_checks = 0;
    int n_fail   = 0;
    int m_ptr    = 0;   // reference round-robin pointer

    mem_port_arbiter #(.NR_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_addr       (req_addr),
        .i_req_wen        (req_wen),
        .i_req_wdata      (req_wdata),
        .i_req_wmask      (req_wmask),
        .o_resp_valid     (resp_valid),
        .o_resp_rdata     (resp_rdata),
        .o_mem_req_valid  (mem_req_valid),
        .i_mem_req_ready  (mem_req_ready),
        .o_mem_addr       (mem_addr),
        .o_mem_wen        (mem_wen),
        .o_mem_wdata      (mem_wdata),
        .o_mem_wmask      (mem_wmask),
        .i_mem_resp_valid (mem_resp_valid),
        .i_mem_rdata      (mem_rdata)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference winner: first valid requester searching upward from ptr.
    function automatic int ref_pick(input logic [NR-1:0] v, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_rdata"}, resp_rdata, 0);
        chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
        chk({tag, "_mem_payload"}, {mem_addr, mem_wen, mem_wdata, mem_wmask}, 0);
    endtask

    // One full transaction starting in an IDLE cycle (called just after a
    // negedge). Payload comes from the current req_* vectors.
    task automatic run_txn(input logic [NR-1:0] v, input int bp, input int lat,
                           input logic [DW-1:0] rd, output logic [NR-1:0] granted);
        int            w;
        logic [NR-1:0] oh;
        logic [AW-1:0] ea;
        logic          ew;
        logic [DW-1:0] ed;
        logic [MW-1:0] em;
        w  = ref_pick(v, RR ? m_ptr : 0);
        oh = NR'(1) << w;
        ea = req_addr[w*AW +: AW];
        ew = req_wen[w];
        ed = req_wdata[w*DW +: DW];
        em = req_wmask[w*MW +: MW];
        req_valid      = v;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        #1;
        granted = req_ready;
        chk("req_ready_accept", req_ready, oh);
        chk("mem_req_valid_idle", mem_req_valid, 0);
        @(negedge clock);
        // Losers keep waiting; scramble inputs to prove the payload was latched.
        req_valid = v & ~oh;
        req_addr  = {$urandom, $urandom};
        req_wen   = NR'($urandom);
        req_wdata = {$urandom, $urandom};
        req_wmask = 8'($urandom);
        for (int i = 0; i <= bp; i++) begin
            mem_req_ready = (i == bp);
            #1;
            chk("mem_req_valid", mem_req_valid, 1);
            chk("mem_addr", mem_addr, ea);
            chk("mem_wen", mem_wen, ew);
            chk("mem_wdata", mem_wdata, ed);
            chk("mem_wmask", mem_wmask, em);
            chk("req_ready_busy", req_ready, 0);
            chk("resp_valid_issue", resp_valid, 0);
            @(negedge clock);
        end
        mem_req_ready = 1'b0;
        for (int j = 0; j < lat; j++) begin
            mem_resp_valid = (j == lat - 1);
            mem_rdata      = (j == lat - 1) ? rd : $urandom;
            #1;
            chk("mem_req_valid_wait", mem_req_valid, 0);
            chk("resp_valid_wait", resp_valid, 0);
            chk("req_ready_wait", req_ready, 0);
            @(negedge clock);
        end
        mem_resp_valid = 1'b0;
        mem_rdata      = $urandom;
        #1;
        chk("resp_valid", resp_valid, oh);
        if (!ew) chk("resp_rdata", resp_rdata, rd);
        chk("req_ready_resp", req_ready, 0);
        @(negedge clock);
        #1;
        chk("resp_valid_single", resp_valid, 0);
        chk("mem_req_valid_after", mem_req_valid, 0);
        if (RR) m_ptr = (w + 1) % NR;
    endtask

    initial begin : main
        logic [NR-1:0] g;
        logic [NR-1:0] v;

        // Reset state
        #1;
        chk_all_zero("reset");
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        #1;
        chk_all_zero("post_reset");

        // Single read from requester 0, minimum latency
        req_addr  = {32'h1111_0000, 32'h8000_0000};
        req_wen   = 2'b00;
        run_txn(2'b01, 0, 1, 32'hDEAD_BEEF, g);
        chk("single_read_grant", g, 2'b01);

        // Write from requester 1
        req_addr  = {32'h0000_0040, 32'h0};
        req_wen   = 2'b10;
        req_wdata = {32'h0000_1234, 32'hFFFF_FFFF};
        req_wmask = {4'h3, 4'hF};
        run_txn(2'b10, 0, 1, $urandom, g);
        chk("write_grant", g, 2'b10);

        // Memory back-pressure for 5 cycles
        req_wen = 2'b00;
        run_txn(2'b01, 5, 2, 32'hCAFE_0001, g);

        // Spurious memory response in IDLE
        req_valid = '0;
        mem_resp_valid = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        #1;
        chk("spur_req_ready", req_ready, 0);
        @(negedge clock);
        mem_resp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("spur_resp_valid", resp_valid, 0);
            chk("spur_mem_req_valid", mem_req_valid, 0);
            @(negedge clock);
        end

        // Reset during WAIT; first make sure an RR pointer would be non-zero.
        run_txn(2'b01, 0, 1, $urandom, g);
        req_valid = 2'b01;
        @(negedge clock);
        req_valid = '0;
        mem_req_ready = 1'b1;
        @(negedge clock);
        mem_req_ready = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("wait_mem_req_valid", mem_req_valid, 0);
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(negedge clock);
        mem_resp_valid = 1'b1;
        #1;
        chk("reset_hold_resp", resp_valid, 0);
        @(negedge clock);
        mem_resp_valid = 1'b0;
        req_valid = '0;
        reset_n = 1'b1;
        m_ptr = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_abort_resp", resp_valid, 0);
            chk("post_abort_mreq", mem_req_valid, 0);
            @(negedge clock);
        end

        // Contention: both requesters valid for three transactions
        run_txn(2'b11, 0, 1, $urandom, g);
        chk("contend_0", g, 2'b01);
        run_txn(2'b11, 0, 1, $urandom, g);
        chk("contend_1", g, RR ? 2'b10 : 2'b01);
        run_txn(2'b11, 1, 1, $urandom, g);
        chk("contend_2", g, 2'b01);

        // Randomized transactions with idle gaps and spurious pulses
        for (int n = 0; n < 40; n++) begin
            v         = NR'($urandom_range(1, 3));
            req_addr  = {$urandom, $urandom};
            req_wen   = NR'($urandom);
            req_wdata = {$urandom, $urandom};
            req_wmask = 8'($urandom);
            run_txn(v, $urandom_range(0, 3), $urandom_range(1, 3), $urandom, g);
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                req_valid = '0;
                mem_resp_valid = 1'($urandom);
                #1;
                chk("rand_idle_ready", req_ready, 0);
                @(negedge clock);
                mem_resp_valid = 1'b0;
                #1;
                chk("rand_idle_resp", resp_valid, 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
